// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: sequences the UART receiver and frames its bytes into fixed-length
// commands (header + payload [+ checksum]) with a cmd_rdy/clr_cmd_rdy handshake.
// Build option: define UART_CMD_CHKSUM_EN to require a trailing checksum byte whose
// mod-256 sum with the payload is zero; undefined, frames are header + payload only.
module uart_cmd_ctrl #(
  parameter int unsigned PAYLOAD_BYTES = 2,
  parameter logic [7:0]  HDR_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS  = 52083
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic [7:0]                 rx_data,
  output logic                       clr_rdy,
  input  logic                       clr_cmd_rdy,
  output logic [8*PAYLOAD_BYTES-1:0] cmd,
  output logic                       cmd_rdy,
  output logic                       frame_err,
  output logic                       overrun
);

  localparam int unsigned CmdW   = 8 * PAYLOAD_BYTES;
  localparam int unsigned CntW   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CntW-1:0]   LastCnt   = CntW'(PAYLOAD_BYTES - 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CLKS - 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
`ifdef UART_CMD_CHKSUM_EN
    StChk,
`endif
    StCommit
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [TimerW-1:0] timer_q;
  logic [CmdW-1:0]   asm_q;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]        acc_q;
  logic [7:0]        chk_sum;
`endif

  logic              timer_hit;
  logic [TimerW-1:0] timer_inc;
  logic [CmdW-1:0]   asm_shift;

  // Every byte offered by the receiver is consumed the same cycle, whatever the state.
  assign clr_rdy = rdy;

  // Timer expiry detection, saturating increment and the payload shift-in value.
  always_comb begin
    timer_hit = (timer_q >= TimerLast);
    timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + TimerW'(1);
    asm_shift = (asm_q << 8) | CmdW'(rx_data);
`ifdef UART_CMD_CHKSUM_EN
    // 8-bit add: the carry out is dropped so the check is mod 256.
    chk_sum   = acc_q + rx_data;
`endif
  end

  // Frame sequencer with registered command, handshake and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timer_q   <= '0;
      asm_q     <= '0;
`ifdef UART_CMD_CHKSUM_EN
      acc_q     <= '0;
`endif
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A set in StCommit below overrides this clear.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          // Non-header bytes are dropped; only the header opens a frame.
          if (rdy && (rx_data == HDR_BYTE)) begin
            state_q <= StPayload;
            cnt_q   <= '0;
            timer_q <= '0;
`ifdef UART_CMD_CHKSUM_EN
            acc_q   <= '0;
`endif
          end
        end

        StPayload: begin
          // A header value here is payload data, never a resync.
          if (rdy) begin
            asm_q   <= asm_shift;
            cnt_q   <= cnt_q + CntW'(1);
            timer_q <= '0;
`ifdef UART_CMD_CHKSUM_EN
            acc_q   <= chk_sum;
            if (cnt_q == LastCnt) begin
              state_q <= StChk;
            end
`else
            if (cnt_q == LastCnt) begin
              state_q <= StCommit;
            end
`endif
          end else if (timer_hit) begin
            frame_err <= 1'b1;
            timer_q   <= '0;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_inc;
          end
        end

`ifdef UART_CMD_CHKSUM_EN
        StChk: begin
          if (rdy) begin
            timer_q <= '0;
            if (chk_sum == 8'h00) begin
              state_q <= StCommit;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StIdle;
            end
          end else if (timer_hit) begin
            frame_err <= 1'b1;
            timer_q   <= '0;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_inc;
          end
        end
`endif

        StCommit: begin
          // A byte arriving on this single cycle is consumed and dropped.
          cmd     <= asm_q;
          cmd_rdy <= 1'b1;
          overrun <= cmd_rdy && !clr_cmd_rdy;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a byte-level frame model predicts commits and
// frame errors; a negedge monitor pops and compares whenever the DUT reports one.
module tb_uart_cmd_ctrl;

  localparam int unsigned PB  = 2;
  localparam logic [7:0]  HDR = 8'hA5;
  localparam int unsigned TO  = 20;
  localparam int unsigned W   = 8 * PB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rdy = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         clr_cmd_rdy = 1'b0;
  logic         clr_rdy;
  logic [W-1:0] cmd;
  logic         cmd_rdy;
  logic         frame_err;
  logic         overrun;

  uart_cmd_ctrl #(
    .PAYLOAD_BYTES(PB),
    .HDR_BYTE     (HDR),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .rx_data    (rx_data),
    .clr_rdy    (clr_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] cmd;
    bit           ovr;
    int           cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (byte level) ----------------
  bit           m_in_frame;
  logic [7:0]   m_bytes[$];
  int           m_last_cyc;
  bit           m_cmd_rdy;
  bit           m_pending;
  logic [W-1:0] m_pend_cmd;
  int           m_pend_cyc;

  task automatic model_reset();
    m_in_frame = 0;
    m_bytes.delete();
    m_cmd_rdy  = 0;
    m_pending  = 0;
  endtask

  task automatic push_err(input int c);
    exp_t e;
    e.is_err = 1; e.cmd = '0; e.ovr = 0; e.cyc = c;
    q.push_back(e);
  endtask

  // Called before an idle stretch of g cycles; ack rides on the first of them.
  task automatic model_gap(input int g, input bit ack);
    exp_t e;
    chk("cmd_rdy_level", 64'(cmd_rdy), 64'(m_cmd_rdy));
    if (m_pending) begin
      e.is_err = 0; e.cmd = m_pend_cmd; e.ovr = m_cmd_rdy && !ack; e.cyc = m_pend_cyc;
      q.push_back(e);
      m_cmd_rdy = 1;
      m_pending = 0;
    end else if (ack) begin
      m_cmd_rdy = 0;
    end
    if (m_in_frame && g >= int'(TO)) begin
      push_err(m_last_cyc + int'(TO));
      m_in_frame = 0;
    end
  endtask

  task automatic model_finish(input int c);
    logic [W-1:0] v;
    v = '0;
    foreach (m_bytes[i]) v = (v << 8) | W'(m_bytes[i]);
    m_in_frame = 0;
    m_pending  = 1;
    m_pend_cmd = v;
    m_pend_cyc = c + 1;
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    int s;
    if (!m_in_frame) begin
      if (b == HDR) begin
        m_in_frame = 1;
        m_bytes.delete();
      end
    end else if (m_bytes.size() < int'(PB)) begin
      m_bytes.push_back(b);
`ifndef UART_CMD_CHKSUM_EN
      if (m_bytes.size() == int'(PB)) model_finish(c);
`endif
    end else begin
      s = int'(b);
      foreach (m_bytes[i]) s += int'(m_bytes[i]);
      if (s % 256 == 0) model_finish(c);
      else begin
        push_err(c);
        m_in_frame = 0;
      end
    end
    m_last_cyc = c;
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int g, input bit ack);
    model_gap(g, ack);
    for (int i = 0; i < g; i++) begin
      rdy = 1'b0;
      clr_cmd_rdy = ack && (i == 0);
      @(posedge clk); #1;
    end
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int g, input bit ack);
    idle(g, ack);
    rdy = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rdy = 1'b0;
    rx_data = 8'($urandom);
    model_byte(b, cyc);
  endtask

  task automatic send_frame(input logic [W-1:0] p, input int g0, input bit ack0, input int gi);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    send(HDR, g0, ack0);
    for (int i = int'(PB) - 1; i >= 0; i--) begin
      b = p[8*i +: 8];
      s = s + b;
      send(b, gi, 1'b0);
    end
`ifdef UART_CMD_CHKSUM_EN
    send(8'h00 - s, gi, 1'b0);
`else
    if (s == 8'h00) b = 8'h00;
`endif
  endtask

  function automatic int rand_gap_in();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return int'(TO) - 1;
    if (r == 1) return int'(TO) + int'($urandom_range(0, 3));
    return int'($urandom_range(1, 3));
  endfunction

  // ---------------- monitor ----------------
  logic         prev_rdy;
  logic [W-1:0] prev_cmd;

  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (!rst_n) begin
      prev_rdy = 1'b0;
      prev_cmd = '0;
    end else begin
      chk("clr_rdy_follows_rdy", 64'(clr_rdy), 64'(rdy));
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL missing_event: expected at cycle %0d (err=%0b), none by cycle %0d",
                 q[0].cyc, q[0].is_err, cyc);
        void'(q.pop_front());
      end
      if (frame_err === 1'b1) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame_err: seen at cycle %0d, expected none", cyc);
        end else begin
          e = q.pop_front();
          if (!e.is_err) begin
            checks++; failures++;
            $display("FAIL event_kind: got frame_err at %0d, expected commit of %0h", cyc, e.cmd);
          end else chk("frame_err_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (overrun === 1'b1 && cmd_rdy !== 1'b1) begin
        checks++; failures++;
        $display("FAIL overrun_without_cmd_rdy: got cmd_rdy %0b, expected 1", cmd_rdy);
      end
      ev = (cmd_rdy === 1'b1) && (!prev_rdy || overrun === 1'b1 || cmd !== prev_cmd);
      if (ev) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_commit: got cmd %0h at cycle %0d, expected none", cmd, cyc);
        end else begin
          e = q.pop_front();
          if (e.is_err) begin
            checks++; failures++;
            $display("FAIL event_kind: got commit %0h at %0d, expected frame_err", cmd, cyc);
          end else begin
            chk("commit_cmd", 64'(cmd), 64'(e.cmd));
            chk("commit_overrun", 64'(overrun), 64'(e.ovr));
            chk("commit_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
      prev_rdy = cmd_rdy;
      prev_cmd = cmd;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]   b;
    logic [W-1:0] p;
    int           k;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd", 64'(cmd), 64'd0);
    chk("reset_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;

    // Basic frame.
    send_frame(16'h1234, 2, 1'b0, 1);
    idle(3, 1'b0);
    chk("t1_cmd", 64'(cmd), 64'h1234);
    chk("t1_cmd_rdy", 64'(cmd_rdy), 64'd1);

`ifdef UART_CMD_CHKSUM_EN
    send(HDR, 1, 1'b1); send(8'h12, 1, 1'b0); send(8'h34, 1, 1'b0); send(8'hBA, 1, 1'b0);
    idle(3, 1'b0);
    chk("t2_good_chk_cmd", 64'(cmd), 64'h1234);
    send(HDR, 1, 1'b1); send(8'h56, 1, 1'b0); send(8'h78, 1, 1'b0); send(8'h00, 1, 1'b0);
    idle(3, 1'b0);
    chk("t2_bad_chk_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("t2_bad_chk_cmd_kept", 64'(cmd), 64'h1234);
`endif

    // Leading junk dropped.
    send(8'h00, 2, 1'b1); send(8'hFF, 1, 1'b0);
    send_frame(16'h5678, 1, 1'b0, 1);
    idle(3, 1'b0);
    chk("t3_cmd", 64'(cmd), 64'h5678);

    // Overrun, then ack on the commit clock of a third frame.
    send_frame(16'h1111, 2, 1'b1, 1);
    send_frame(16'h2222, 2, 1'b0, 2);
    idle(3, 1'b0);
    chk("t5_overrun_cmd", 64'(cmd), 64'h2222);
    send_frame(16'h3333, 2, 1'b0, 1);
    idle(3, 1'b1);
    chk("t5_ack_at_commit_cmd_rdy", 64'(cmd_rdy), 64'd1);

    // Header as payload data; inter-byte gap one short of the timeout.
    send_frame({HDR, HDR}, 2, 1'b1, int'(TO) - 1);
    idle(3, 1'b0);
    chk("hdr_in_payload_cmd", 64'(cmd), {48'd0, HDR, HDR});

    // Timeout mid-frame, then recovery.
    send(HDR, 2, 1'b1); send(8'h12, 1, 1'b0);
    idle(int'(TO), 1'b0);
    send_frame(16'h9ABC, 3, 1'b0, 1);
    idle(3, 1'b0);
    chk("t4_cmd", 64'(cmd), 64'h9ABC);

    // Asynchronous reset mid-frame.
    send(HDR, 2, 1'b0); send(8'h12, 1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("t6_rst_cmd", 64'(cmd), 64'd0);
    chk("t6_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("t6_queue_drained", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(int'(TO) + 3, 1'b0);
    send_frame(16'hABCD, 1, 1'b0, 1);
    idle(3, 1'b0);
    chk("t6_cmd", 64'(cmd), 64'hABCD);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 2) begin
        b = 8'($urandom);
        if (b == HDR) b = 8'h00;
        send(b, int'($urandom_range(1, 4)), ($urandom_range(0, 2) == 0));
      end else begin
        send(HDR, int'($urandom_range(1, 4)), ($urandom_range(0, 2) == 0));
        p = W'($urandom);
        b = 8'h00;
        for (int i = int'(PB) - 1; i >= 0; i--) begin
          if ($urandom_range(0, 4) == 0) p[8*i +: 8] = HDR;
          b = b + p[8*i +: 8];
          send(p[8*i +: 8], rand_gap_in(), 1'b0);
        end
`ifdef UART_CMD_CHKSUM_EN
        b = 8'h00 - b;
        if ($urandom_range(0, 4) == 0) b = b ^ 8'($urandom_range(1, 255));
        send(b, rand_gap_in(), 1'b0);
`endif
      end
    end

    idle(int'(TO) + 5, 1'b0);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
